// File: rtl/sb_pkg.sv
// sb_pkg: shared FSM states, peripheral slot map and error word for the system-bus arbiter.
package sb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [7:0] SLOT_MEM   = 8'd0;
  localparam logic [7:0] SLOT_PS2   = 8'd3;
  localparam logic [7:0] SLOT_UART  = 8'd6;
  localparam logic [7:0] SLOT_VGA   = 8'd7;
  localparam logic [7:0] SLOT_TIMER = 8'd8;
  localparam logic [31:0] DEADBEEF  = 32'hDEAD_BEEF;
  function automatic logic slot_mapped(input logic [7:0] s);
    return s inside {SLOT_MEM, SLOT_PS2, SLOT_UART, SLOT_VGA, SLOT_TIMER};
  endfunction
endpackage

// File: rtl/sb_rr_arbiter.sv
// sb_rr_arbiter: 2-way round-robin grant with m0 lock-out mask and last-grant register.
module sb_rr_arbiter (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic req0,
  input  logic req1,
  input  logic lock,
  input  logic take,
  output logic valid,
  output logic idx
);
  logic last;
  logic e0;
  assign e0 = req0 & ~lock;
  assign valid = e0 | req1;
  // on a tie the master that did not win last time gets the bus
  assign idx = (e0 & req1) ? ~last : req1;
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) last <= 1'b1;
    else if (take) last <= idx;
endmodule

// File: rtl/sb_arbiter.sv
// sb_arbiter: arbitrates core LSU (m0) and loader (m1) onto the shared peripheral bus.
module sb_arbiter
  import sb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  output logic [31:0] m0_rd_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  output logic [31:0] m1_rd_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  input  logic        m1_lock_i,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wd_o,
  output logic [7:0]  s_slot_o,
  output logic [31:0] s_addr_o,
  input  logic [31:0] s_rd_i,
  input  logic        s_ready_i
);
  state_e state;
  logic [7:0] cnt;
  logic sel, gnt_valid, gnt_idx;
  logic w_we;
  logic [3:0] w_be;
  logic [31:0] w_addr, w_wd, rsp_rd;
  logic unmapped, timed_out, rsp_go, rsp_err;
  sb_rr_arbiter u_rr (
    .clk_i(clk_i), .resetn_i(resetn_i), .req0(m0_req_i), .req1(m1_req_i), .lock(m1_lock_i),
    .take(state == IDLE && gnt_valid), .valid(gnt_valid), .idx(gnt_idx)
  );
  assign w_we = gnt_idx ? m1_we_i : m0_we_i;
  assign w_be = gnt_idx ? m1_be_i : m0_be_i;
  assign w_addr = gnt_idx ? m1_addr_i : m0_addr_i;
  assign w_wd = gnt_idx ? m1_wd_i : m0_wd_i;
  // completion wins over timeout when both land on the same cycle
  assign unmapped = state == ISSUE && !slot_mapped(s_slot_o);
  assign timed_out = state == WAIT && !s_ready_i && cnt == 8'(TIMEOUT - 1);
  assign rsp_go = unmapped || ((state == ISSUE || state == WAIT) && s_ready_i) || timed_out;
  assign rsp_err = unmapped || timed_out;
  assign rsp_rd = rsp_err ? DEADBEEF : s_rd_i;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= IDLE;
      cnt <= 8'd0;
      sel <= 1'b0;
      s_req_o <= 1'b0;
      s_we_o <= 1'b0;
      s_be_o <= 4'd0;
      s_wd_o <= 32'd0;
      s_slot_o <= 8'd0;
      s_addr_o <= 32'd0;
      m0_ready_o <= 1'b0;
      m1_ready_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      m0_rd_o <= 32'd0;
      m1_rd_o <= 32'd0;
    end else begin
      s_req_o <= 1'b0;
      m0_ready_o <= 1'b0;
      m1_ready_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      m0_rd_o <= 32'd0;
      m1_rd_o <= 32'd0;
      if (state == IDLE && gnt_valid) begin
        sel <= gnt_idx;
        s_req_o <= slot_mapped(w_addr[31:24]);
        s_we_o <= w_we;
        s_be_o <= w_be;
        s_wd_o <= w_wd;
        s_slot_o <= w_addr[31:24];
        s_addr_o <= {8'd0, w_addr[23:0]};
        state <= ISSUE;
      end else if (rsp_go) begin
        m0_ready_o <= ~sel;
        m1_ready_o <= sel;
        m0_err_o <= ~sel & rsp_err;
        m1_err_o <= sel & rsp_err;
        m0_rd_o <= sel ? 32'd0 : rsp_rd;
        m1_rd_o <= sel ? rsp_rd : 32'd0;
        state <= RESP;
      end else if (state == ISSUE) begin
        cnt <= 8'd0;
        state <= WAIT;
      end else if (state == WAIT) cnt <= cnt + 8'd1;
      else if (state == RESP) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sb_arbiter.sv
// tb_sb_arbiter: directed and random transactions checked against a rule-level bus model.
module tb_sb_arbiter;
  localparam int TIMEOUT = 255;
  logic clk_i = 1'b0, resetn_i = 1'b0;
  logic m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0, m1_lock_i = 0, s_ready_i = 0;
  logic [3:0] m0_be_i = 0, m1_be_i = 0, s_be_o;
  logic [31:0] m0_addr_i = 0, m0_wd_i = 0, m1_addr_i = 0, m1_wd_i = 0, s_rd_i = 0;
  logic [31:0] m0_rd_o, m1_rd_o, s_wd_o, s_addr_o;
  logic m0_ready_o, m0_err_o, m1_ready_o, m1_err_o, s_req_o, s_we_o;
  logic [7:0] s_slot_o;
  logic [7:0] slots [7] = '{8'd0, 8'd3, 8'd6, 8'd7, 8'd8, 8'd5, 8'hFF};
  int checks = 0, errors = 0;
  int last_w = 1;
  always #5 clk_i = ~clk_i;
  sb_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i), .m0_wd_i(m0_wd_i),
    .m0_rd_o(m0_rd_o), .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i), .m1_wd_i(m1_wd_i),
    .m1_rd_o(m1_rd_o), .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o), .m1_lock_i(m1_lock_i),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wd_o(s_wd_o), .s_slot_o(s_slot_o),
    .s_addr_o(s_addr_o), .s_rd_i(s_rd_i), .s_ready_i(s_ready_i)
  );
  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit mapped(input logic [7:0] s);
    return s == 8'd0 || s == 8'd3 || s == 8'd6 || s == 8'd7 || s == 8'd8;
  endfunction
  function automatic logic [191:0] all_out();
    return {m0_rd_o, m0_ready_o, m0_err_o, m1_rd_o, m1_ready_o, m1_err_o,
            s_req_o, s_we_o, s_be_o, s_wd_o, s_slot_o, s_addr_o};
  endfunction
  // called at an IDLE negedge with request inputs already set; d = WAIT cycles before s_ready_i
  task automatic run_txn(input int d, input logic [31:0] rdval, input bit raise_lock);
    bit e0, e1, mp, err;
    int w, pe;
    logic we;
    logic [3:0] be;
    logic [31:0] a, wd;
    e0 = m0_req_i && !m1_lock_i;
    e1 = m1_req_i;
    if (!e0 && !e1) begin
      @(posedge clk_i); @(negedge clk_i);
      chk("idle_sreq", s_req_o, 0);
      chk("idle_ready", {m0_ready_o, m1_ready_o}, 0);
      return;
    end
    w = (e0 && e1) ? (last_w == 1 ? 0 : 1) : (e1 ? 1 : 0);
    last_w = w;
    {we, be, a, wd} = w ? {m1_we_i, m1_be_i, m1_addr_i, m1_wd_i} : {m0_we_i, m0_be_i, m0_addr_i, m0_wd_i};
    mp = mapped(a[31:24]);
    pe = !mp ? 0 : (d < TIMEOUT ? d : TIMEOUT);
    err = !mp || d >= TIMEOUT;
    @(posedge clk_i); @(negedge clk_i);
    if (mp) chk("issue_fields", {s_we_o, s_be_o, s_slot_o, s_addr_o, s_wd_o}, {we, be, a[31:24], 8'd0, a[23:0], wd});
    for (int p = 0; p <= pe; p++) begin
      chk("sreq", s_req_o, (p == 0 && mp));
      chk("no_early_ready", {m0_ready_o, m1_ready_o}, 0);
      if (raise_lock && p == 0) m1_lock_i = 1'b1;
      s_ready_i = mp && p == d;
      s_rd_i = s_ready_i ? rdval : $urandom;
      @(posedge clk_i); @(negedge clk_i);
    end
    s_ready_i = 1'b0;
    chk("ready", {m0_ready_o, m1_ready_o}, w ? 2'b01 : 2'b10);
    chk("err", {m0_err_o, m1_err_o}, w ? {1'b0, err} : {err, 1'b0});
    chk("other_rd", w ? m0_rd_o : m1_rd_o, 0);
    if (mp) chk("rd", w ? m1_rd_o : m0_rd_o, err ? 32'hDEAD_BEEF : rdval);
    @(posedge clk_i); @(negedge clk_i);
    chk("ready_pulse", {m0_ready_o, m1_ready_o, m0_rd_o, m1_rd_o}, 0);
  endtask
  initial begin
    #1 chk("reset_outs", all_out(), 0);
    @(negedge clk_i); @(negedge clk_i);
    resetn_i = 1'b1;
    m0_req_i = 1; m0_we_i = 0; m0_be_i = 4'hF; m0_addr_i = 32'h0000_0010;
    run_txn(0, 32'h1234_5678, 0);
    m1_req_i = 1; m1_addr_i = 32'h0000_0040; m1_wd_i = 32'hCAFE_0001; m1_we_i = 1; m1_be_i = 4'h3;
    m0_addr_i = 32'h0300_0004;
    for (int i = 0; i < 4; i++) run_txn(0, $urandom, 0);
    m1_lock_i = 1;
    for (int i = 0; i < 4; i++) run_txn(1, $urandom, 0);
    m1_lock_i = 0; m1_req_i = 0;
    run_txn(2, 32'hA5A5_0F0F, 1);
    m1_req_i = 1;
    run_txn(0, 32'h0BAD_F00D, 0);
    m1_lock_i = 0; m1_req_i = 0;
    m0_we_i = 1; m0_addr_i = 32'h0500_0000; m0_wd_i = 32'h1111_2222;
    run_txn(0, 32'h0, 0);
    m0_we_i = 0; m0_addr_i = 32'h0700_0004;
    run_txn(1000, 32'h0, 0);
    m0_addr_i = 32'h0600_0008;
    @(posedge clk_i); @(negedge clk_i);
    s_ready_i = 0;
    @(posedge clk_i); @(negedge clk_i);
    @(posedge clk_i); #2;
    resetn_i = 1'b0;
    #1 chk("reset_async", all_out(), 0);
    @(negedge clk_i);
    chk("reset_hold", all_out(), 0);
    @(negedge clk_i);
    chk("reset_no_ready", all_out(), 0);
    m1_req_i = 1; m1_addr_i = 32'h0800_0000;
    resetn_i = 1'b1;
    last_w = 1;
    run_txn(0, 32'h5555_AAAA, 0);
    for (int i = 0; i < 80; i++) begin
      m0_req_i = ($urandom_range(0, 3) != 0);
      m1_req_i = 1'($urandom_range(0, 1));
      m1_lock_i = ($urandom_range(0, 4) == 0);
      m0_we_i = 1'($urandom_range(0, 1));
      m1_we_i = 1'($urandom_range(0, 1));
      m0_be_i = 4'($urandom);
      m1_be_i = 4'($urandom);
      m0_addr_i = {slots[$urandom_range(0, 6)], 24'($urandom)};
      m1_addr_i = {slots[$urandom_range(0, 6)], 24'($urandom)};
      m0_wd_i = $urandom;
      m1_wd_i = $urandom;
      run_txn($urandom_range(0, 4), $urandom, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sb_arbiter.md
SB_ARBITER -- requirements
Module: sb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: number of WAIT-state cycles without s_ready_i before an error response is returned.
REQ-002 clk_i  in  1  system clock; all state changes on its rising edge.
REQ-003 resetn_i  in  1  asynchronous, active-low reset.
REQ-004 m0_req_i, m0_we_i  in  1 each  core LSU request and write-enable, held until m0_ready_o.
REQ-005 m0_be_i  in  4 / m0_addr_i  in  32 / m0_wd_i  in  32  core LSU byte enables, address and write data, stable while m0_req_i is high.
REQ-006 m0_rd_o  out  32 / m0_ready_o  out  1 / m0_err_o  out  1  core LSU read data, one-cycle completion strobe and error flag.
REQ-007 m1_* (req, we, be, addr, wd, rd, ready, err)  same widths  loader/programmer port, identical semantics.
REQ-008 m1_lock_i  in  1  when high, m1 owns the bus exclusively.
REQ-009 s_req_o, s_we_o  out  1 / s_be_o  out  4 / s_wd_o  out  32  shared peripheral bus request, write-enable, byte enables and write data.
REQ-010 s_slot_o  out  8 / s_addr_o  out  32  peripheral slot (addr[31:24]) and offset {8'd0, addr[23:0]}.
REQ-011 s_rd_i  in  32 / s_ready_i  in  1  muxed peripheral read data and completion.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: if any eligible request is present, the block SHALL latch the winner's we/be/addr/wd and its index, then go to ISSUE; otherwise stay in IDLE.
REQ-014 Eligibility: m0 is ineligible while m1_lock_i=1; m1 is always eligible.
REQ-015 Tie (both eligible): the master not granted last wins; last-grant register resets to m1, so m0 wins the first tie.
REQ-016 ISSUE: s_req_o=1 for exactly one cycle with the latched fields; an unmapped slot (not in {0,3,6,7,8}) SHALL NOT assert s_req_o and goes to RESP with error.
REQ-017 ISSUE and WAIT: s_ready_i=1 captures s_rd_i and goes to RESP; otherwise the state goes to/stays in WAIT.
REQ-018 WAIT: an 8-bit counter, cleared on entry, increments each cycle; reaching TIMEOUT goes to RESP with error and rd=32'hDEAD_BEEF.
REQ-019 RESP: winner's mX_ready_o=1 for one cycle with captured rd and err; the other master's outputs stay 0; next state IDLE.
REQ-020 Latency with s_ready_i in ISSUE: request in IDLE at cycle N, s_req_o at N+1, mX_ready_o at N+2.
REQ-021 s_* outputs are 0 outside ISSUE except that held latched values are allowed; mX_rd_o is 0 when mX_ready_o=0.
REQ-022 m1_lock_i rising mid-transaction of m0: the m0 transaction completes normally; the lock takes effect at the next IDLE arbitration.
REQ-023 A master dropping req before ready is a protocol violation; the latched transaction still completes and its response is discarded by that master.

Reset
REQ-024 While resetn_i=0: state=IDLE, counter=0, last-grant=m1, and all outputs 0, asynchronously.
REQ-025 Reset mid-transaction aborts it with no ready strobe; the first arbitration after release occurs on the first rising edge with resetn_i=1.

Structure
REQ-026 Shared package sb_pkg: FSM state enum, slot constants (MEM=0, PS2=3, UART=6, VGA=7, TIMER=8), DEADBEEF error word.
REQ-027 One sub-module, sb_rr_arbiter: 2-way round-robin with lock mask, combinational grant plus last-grant register.

Verification
REQ-028 m0 read of 0x0000_0010, s_ready_i in ISSUE with rd=0x1234_5678 -> m0_ready_o at cycle 2, m0_rd_o=0x1234_5678, err=0.
REQ-029 m0 and m1 requesting continuously -> grants alternate m0, m1, m0, m1, with no idle cycle beyond IDLE.
REQ-030 m1_lock_i=1 with both requesting for 4 transactions -> all grants go to m1; m0_ready_o stays 0.
REQ-031 m0 write to 0x0500_0000 (unmapped) -> no s_req_o, m0_ready_o=1, m0_err_o=1.
REQ-032 s_ready_i never asserted, TIMEOUT=255 -> m0_ready_o=1 with err=1 and rd=0xDEAD_BEEF exactly 255 WAIT cycles after ISSUE.
REQ-033 resetn_i pulled low during WAIT -> outputs 0 immediately and no ready strobe; after release, m0 wins the first tie.
